// File: rtl/chn_arb.sv
// chn_arb - round-robin token arbiter for the shared PCIe TRN transmit bus.
//
// Hands a single one-hot token to one of N_CHN channels at a time, leaves one
// empty cycle between owners so the OR-combined TRN bus never sees two
// drivers, and presents the whole group upstream as one requester.
//
// Ports:
//   pcie_clk     clock, rising edge
//   pcie_rst     synchronous active-high reset
//   chn_reqep    per-channel endpoint request
//   chn_drvn     per-channel "driving TRN tx" flag
//   chn_trn      one-hot token to the channels (registered)
//   arb_trn      upstream token for this group
//   arb_reqep    OR of chn_reqep (combinational)
//   arb_drvn     OR of chn_drvn (combinational)
//   owner        current or last token holder (registered)
//   busy         high while in GRANT or BUSY (registered)
//   timeout_err  one-cycle pulse when a grant expires without drive
//   proto_err    one-cycle pulse when a non-holder drives
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | no token out, waiting for upstream token and a request
// GRANT   | token issued, waiting for the holder to start driving
// BUSY    | holder is driving a TLP burst; never aborted
// RELEASE | one-cycle turnaround with no token; may re-grant directly

module chn_arb #(
    parameter int IDX_W         = 2,
    parameter int GRANT_TIMEOUT = 64
) (
    input  logic                  pcie_clk,
    input  logic                  pcie_rst,
    input  logic [2**IDX_W-1:0]   chn_reqep,
    input  logic [2**IDX_W-1:0]   chn_drvn,
    output logic [2**IDX_W-1:0]   chn_trn,
    input  logic                  arb_trn,
    output logic                  arb_reqep,
    output logic                  arb_drvn,
    output logic [IDX_W-1:0]      owner,
    output logic                  busy,
    output logic                  timeout_err,
    output logic                  proto_err
);

    localparam int N_CHN = 2**IDX_W;
    localparam logic [15:0] HOLD_LAST = 16'(GRANT_TIMEOUT - 1);
    localparam logic [N_CHN-1:0] ONE_HOT_0 = {{(N_CHN-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_BUSY,
        S_RELEASE
    } state_t;

    state_t            state;
    logic [15:0]       hold_cnt;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_vld;
    logic [IDX_W-1:0]  cand;
    logic              drv_own;
    logic              req_own;

    assign arb_reqep = |chn_reqep;
    assign arb_drvn  = |chn_drvn;
    assign drv_own   = chn_drvn[owner];
    assign req_own   = chn_reqep[owner];

    // Scan from farthest (owner itself) to nearest (owner+1); the last hit
    // wins, so the nearest requester after the current owner is chosen.
    always_comb begin
        pick_idx = owner;
        pick_vld = 1'b0;
        cand     = owner;
        for (int k = N_CHN; k >= 1; k--) begin
            cand = owner + IDX_W'(k);
            if (chn_reqep[cand]) begin
                pick_idx = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            state       <= S_IDLE;
            chn_trn     <= '0;
            owner       <= IDX_W'(N_CHN - 1);
            hold_cnt    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            proto_err   <= |(chn_drvn & ~chn_trn);
            case (state)
                S_IDLE, S_RELEASE: begin
                    if (arb_trn && pick_vld) begin
                        state    <= S_GRANT;
                        owner    <= pick_idx;
                        chn_trn  <= ONE_HOT_0 << pick_idx;
                        hold_cnt <= '0;
                        busy     <= 1'b1;
                    end else begin
                        state   <= S_IDLE;
                        chn_trn <= '0;
                        busy    <= 1'b0;
                    end
                end
                S_GRANT: begin
                    if (drv_own) begin
                        state <= S_BUSY;
                    end else if (!req_own || !arb_trn) begin
                        state   <= S_RELEASE;
                        chn_trn <= '0;
                        busy    <= 1'b0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state       <= S_RELEASE;
                        chn_trn     <= '0;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 16'd1;
                    end
                end
                S_BUSY: begin
                    // arb_trn is deliberately ignored here: a burst in flight
                    // runs to completion.
                    if (!drv_own) begin
                        state   <= S_RELEASE;
                        chn_trn <= '0;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    chn_trn <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chn_arb.sv
module tb_chn_arb;

    localparam int IDX_W = 2;
    localparam int N_CHN = 4;
    localparam int TMO   = 8;

    logic             clk;
    logic             rst;
    logic [N_CHN-1:0] chn_reqep;
    logic [N_CHN-1:0] chn_drvn;
    logic [N_CHN-1:0] chn_trn;
    logic             arb_trn;
    logic             arb_reqep;
    logic             arb_drvn;
    logic [IDX_W-1:0] owner;
    logic             busy;
    logic             timeout_err;
    logic             proto_err;

    int n_checks = 0;
    int n_errors = 0;

    chn_arb #(.IDX_W(IDX_W), .GRANT_TIMEOUT(TMO)) dut (
        .pcie_clk    (clk),
        .pcie_rst    (rst),
        .chn_reqep   (chn_reqep),
        .chn_drvn    (chn_drvn),
        .chn_trn     (chn_trn),
        .arb_trn     (arb_trn),
        .arb_reqep   (arb_reqep),
        .arb_drvn    (arb_drvn),
        .owner       (owner),
        .busy        (busy),
        .timeout_err (timeout_err),
        .proto_err   (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] exp_order [5];
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2;
        exp_order[3] = 3; exp_order[4] = 0;

        rst = 1'b1; chn_reqep = '0; chn_drvn = '0; arb_trn = 1'b0;
        tick(); tick();
        chk("rst_trn",   chn_trn, 0);
        chk("rst_owner", owner, 3);
        chk("rst_busy",  busy, 0);
        chk("rst_tmo",   timeout_err, 0);
        chk("rst_proto", proto_err, 0);
        chk("rst_arbreq", arb_reqep, 0);

        // first grant, single requester
        rst = 1'b0; chn_reqep = 4'b0001; arb_trn = 1'b1;
        #1;
        chk("arb_reqep_or", arb_reqep, 1);
        tick();
        chk("g1_trn",   chn_trn, 4'b0001);
        chk("g1_owner", owner, 0);
        chk("g1_busy",  busy, 1);
        chn_drvn = 4'b0001;
        #1;
        chk("arb_drvn_or", arb_drvn, 1);
        tick(); tick(); tick();
        chk("g1_hold_trn",  chn_trn, 4'b0001);
        chk("g1_hold_busy", busy, 1);
        chn_drvn = '0; chn_reqep = '0;
        tick();
        chk("g1_rel_trn",  chn_trn, 0);
        chk("g1_rel_busy", busy, 0);
        tick();
        chk("g1_idle_trn", chn_trn, 0);

        // rotation with all four requesting
        rst = 1'b1; tick(); rst = 1'b0;
        chn_reqep = 4'b1111; arb_trn = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("rr_trn",   chn_trn, 32'(1) << exp_order[i]);
            chk("rr_owner", owner, exp_order[i]);
            chn_drvn = 4'(32'(1) << exp_order[i]);
            tick(); tick(); tick();
            chk("rr_hold", chn_trn, 32'(1) << exp_order[i]);
            chn_drvn = '0;
            tick();
            chk("rr_gap", chn_trn, 0);
            if (i < 4) tick();
        end
        chn_reqep = '0;
        tick();
        chk("rr_end_trn",   chn_trn, 0);
        chk("rr_end_owner", owner, 0);
        chk("rr_proto",     proto_err, 0);

        // grant timeout on channel 2
        chn_reqep = 4'b0100;
        tick();
        chk("to_trn",   chn_trn, 4'b0100);
        chk("to_early", timeout_err, 0);
        for (int c = 2; c <= TMO; c++) tick();
        chk("to_last_trn", chn_trn, 4'b0100);
        chk("to_last_err", timeout_err, 0);
        chn_reqep = 4'b0110;
        tick();
        chk("to_pulse",    timeout_err, 1);
        chk("to_rel_trn",  chn_trn, 0);
        chk("to_rel_busy", busy, 0);
        tick();
        chk("to_next_trn",   chn_trn, 4'b0010);
        chk("to_next_owner", owner, 1);
        chk("to_pulse_end",  timeout_err, 0);

        // arb_trn drops while channel 1 is busy
        chn_drvn = 4'b0010;
        tick();
        arb_trn = 1'b0;
        tick(); tick();
        chk("drop_trn",  chn_trn, 4'b0010);
        chk("drop_busy", busy, 1);
        chn_drvn = '0;
        tick();
        chk("drop_rel", chn_trn, 0);
        tick();
        chk("drop_nogrant", chn_trn, 0);
        tick();
        chk("drop_nogrant2", chn_trn, 0);

        // protocol error from a non-holder
        chn_reqep = 4'b0001; arb_trn = 1'b1;
        tick();
        chk("pe_trn",  chn_trn, 4'b0001);
        chk("pe_none", proto_err, 0);
        chn_drvn = 4'b1000;
        tick();
        chk("pe_pulse", proto_err, 1);
        chk("pe_trn_kept", chn_trn, 4'b0001);
        chn_drvn = '0;
        tick();
        chk("pe_clear", proto_err, 0);
        chk("pe_trn_kept2", chn_trn, 4'b0001);

        // reset while busy
        chn_drvn = 4'b0001;
        tick();
        chk("rb_busy", busy, 1);
        rst = 1'b1;
        tick();
        chk("rb_trn",   chn_trn, 0);
        chk("rb_busy0", busy, 0);
        chk("rb_owner", owner, 3);
        rst = 1'b0; chn_drvn = '0; chn_reqep = 4'b1010; arb_trn = 1'b1;
        tick();
        chk("rb_first_trn",   chn_trn, 4'b0010);
        chk("rb_first_owner", owner, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
